// File: rtl/btb_counter_table.sv
// ---------------------------------------------------------------------------
// btb_counter_table
//   Table of saturating branch-direction counters indexed by PC bits. Lives
//   beside the BTB tag/target arrays in fetch; the update port is driven by
//   branch resolution in EX.
//
//   After reset or flush the table sweeps every entry to INIT_VAL, one entry
//   per cycle. During the sweep reads return INIT_VAL and updates are
//   dropped. Once ready, an update reads the addressed counter, saturates it
//   up or down, and writes it back on the next edge. A same-index read in
//   the same cycle sees the updated value (forwarding).
//
// Ports
//   clk         clock, all state changes on posedge
//   rst         synchronous active-high reset, priority over flush/update
//   flush       synchronous request to re-initialise the whole table
//   rindex      prediction read index
//   pred_cnt    counter value at rindex (combinational)
//   pred_taken  MSB of pred_cnt
//   upd_valid   resolved-branch update strobe
//   upd_index   entry to update
//   upd_taken   1 = increment, 0 = decrement
//   ready       table initialised, updates accepted
// ---------------------------------------------------------------------------
module btb_counter_table #(
   parameter int                   SIZE      = 256,
   parameter int                   CNT_WIDTH = 2,
   parameter logic [CNT_WIDTH-1:0] INIT_VAL  = CNT_WIDTH'(1) << (CNT_WIDTH - 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [$clog2(SIZE)-1:0]   rindex,
   output logic [CNT_WIDTH-1:0]      pred_cnt,
   output logic                      pred_taken,
   input  logic                      upd_valid,
   input  logic [$clog2(SIZE)-1:0]   upd_index,
   input  logic                      upd_taken,
   output logic                      ready
);

   localparam int                   IDX_W   = $clog2(SIZE);
   localparam logic [IDX_W-1:0]     LAST    = IDX_W'(SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDX_W-1:0]     r_init_ptr;
   logic [IDX_W-1:0]     w_init_ptr_nxt;
   logic [CNT_WIDTH-1:0] r_data [SIZE];

   logic [CNT_WIDTH-1:0] w_cur;
   logic [CNT_WIDTH-1:0] w_nxt;
   logic                 w_ready;
   logic                 w_upd_en;
   logic                 w_fwd;

   assign w_ready = (r_state == ST_READY);
   assign ready   = w_ready;

   // Saturating read-modify-write value for the update port.
   assign w_cur = r_data[upd_index];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      w_nxt = w_cur;
      if (upd_taken) begin
         if (w_cur != CNT_MAX) w_nxt = w_cur + CNT_WIDTH'(1);
      end else begin
         if (w_cur != '0) w_nxt = w_cur - CNT_WIDTH'(1);
      end
   end

   // An update in a cycle that also re-initialises the table is dropped.
   assign w_upd_en = upd_valid && w_ready && !rst && !flush;
   assign w_fwd    = upd_valid && w_ready && (upd_index == rindex);

   // Next-state logic: flush restarts the sweep from either state.
   always_comb begin
      w_state_nxt    = r_state;
      w_init_ptr_nxt = r_init_ptr;
      if (flush) begin
         w_state_nxt    = ST_INIT;
         w_init_ptr_nxt = '0;
      end else if (r_state == ST_INIT) begin
         // Pointer wraps to 0 after the last entry; it is unused in READY.
         w_init_ptr_nxt = r_init_ptr + IDX_W'(1);
         if (r_init_ptr == LAST) w_state_nxt = ST_READY;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (rst) begin
         r_state    <= ST_INIT;
         r_init_ptr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_ptr <= w_init_ptr_nxt;
      end
   end

   // NOTE: the counter array has no reset; the init sweep gives it a
   // defined value before any read is served from it.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (r_state == ST_INIT) begin
            r_data[r_init_ptr] <= INIT_VAL;
         end else if (w_upd_en) begin
            r_data[upd_index] <= w_nxt;
         end
      end
   end

   // Prediction read: fixed INIT_VAL while sweeping, forwarded update value
   // on a same-index hit, stored counter otherwise.
   always_comb begin
      pred_cnt = r_data[rindex];
      if (!w_ready)   pred_cnt = INIT_VAL;
      else if (w_fwd) pred_cnt = w_nxt;
   end

   assign pred_taken = pred_cnt[CNT_WIDTH-1];

endmodule
